timer_intr_ctrl: RTL and testbench

Memory-mapped machine timer for the three-stage RISC-V core. It holds a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, and drives a level timer-interrupt line. The block sits upstream of the CSR unit: `timer_irq` connects directly to the CSR `intr_exc` input, which sets `mip[7]`. It shares the data-memory bus with the load/store path of the pipeline.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 43 ++++
 rtl/timer_intr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_timer_intr_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: register map, control bit positions and reset constants shared
// by the machine timer (timer_intr_ctrl) and its optional prescaler.
package timer_pkg;

  // Byte offsets of the register window (only bits [4:2] are decoded).
  localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
  localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
  localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TMR_CTRL        = 5'h10;
  localparam logic [4:0] TMR_PRESCALE    = 5'h14;

  // CTRL register bit positions.
  localparam int TMR_CTRL_EN = 0;

  // Reset values: counter at zero, compare parked at the far end so the
  // interrupt cannot fire until software programs a real deadline.
  localparam logic [63:0] TMR_MTIME_RST    = 64'h0000_0000_0000_0000;
  localparam logic [63:0] TMR_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word index of a byte offset, as seen by the address decoder.
  function automatic logic [2:0] tmr_word(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the core clock into single-cycle ticks for mtime.
// A tick fires when the count equals presc_val, then the count restarts at 0,
// so presc_val = N yields one tick every N+1 enabled cycles.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc_val,
  input  logic               presc_wr,
  output logic               tick
);

  logic [PRESC_W-1:0] count_reg;
  logic [PRESC_W-1:0] count_next;

  assign tick = en & (count_reg == presc_val);

  // Next count: a PRESCALE write restarts the period; the count only moves while enabled.
  always_comb begin
    count_next = count_reg;
    if (presc_wr) begin
      count_next = '0;
    end else if (tick) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/timer_intr_ctrl.sv
// timer_intr_ctrl: memory-mapped RISC-V machine timer (mtime / mtimecmp)
// driving a registered level interrupt into the CSR unit (mip[7]).
// Optional feature macro: TIMER_PRESCALER_EN -- when defined, mtime advances
// on prescaler ticks and PRESCALE (0x14) is a real register; when undefined,
// mtime advances every enabled cycle and 0x14 is read-as-zero/write-ignored.
module timer_intr_ctrl
  import timer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              timer_irq
);

  localparam logic [2:0] W_MTIME_LO    = tmr_word(TMR_MTIME_LO);
  localparam logic [2:0] W_MTIME_HI    = tmr_word(TMR_MTIME_HI);
  localparam logic [2:0] W_MTIMECMP_LO = tmr_word(TMR_MTIMECMP_LO);
  localparam logic [2:0] W_MTIMECMP_HI = tmr_word(TMR_MTIMECMP_HI);
  localparam logic [2:0] W_CTRL        = tmr_word(TMR_CTRL);
  localparam logic [2:0] W_PRESCALE    = tmr_word(TMR_PRESCALE);

  // Bus decode. Byte-lane bits [1:0] are deliberately ignored.
  logic [2:0] word_idx;
  logic       wr_fire;
  logic       rd_fire;
  logic       unused_addr_bits;

  assign word_idx         = addr[4:2];
  assign wr_fire          = sel & wr_en;
  assign rd_fire          = sel & rd_en;
  assign unused_addr_bits = ^addr[1:0];

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_ctrl;
  logic wr_presc;
  logic rd_mtime_lo;

  assign wr_mtime_lo = wr_fire & (word_idx == W_MTIME_LO);
  assign wr_mtime_hi = wr_fire & (word_idx == W_MTIME_HI);
  assign wr_ctrl     = wr_fire & (word_idx == W_CTRL);
  assign wr_presc    = wr_fire & (word_idx == W_PRESCALE);
  assign rd_mtime_lo = rd_fire & (word_idx == W_MTIME_LO);

  // State
  logic [63:0] mtime_reg;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow_reg;
  logic        en_reg;
  logic        irq_reg;
  logic        tick;

  // CTRL.EN register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_reg <= 1'b0;
    end else if (wr_ctrl) begin
      en_reg <= wdata[TMR_CTRL_EN];
    end
  end

`ifdef TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_reg;

  // PRESCALE register; the prescaler itself restarts its count on this write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
    end else if (wr_presc) begin
      presc_reg <= wdata[PRESC_W-1:0];
    end
  end

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .en        (en_reg),
    .presc_val (presc_reg),
    .presc_wr  (wr_presc),
    .tick      (tick)
  );
`else
  logic unused_presc_wr;

  assign unused_presc_wr = wr_presc;
  assign tick            = en_reg;
`endif

  // Next mtime: a bus write to either half beats the tick (no increment that
  // cycle); otherwise a tick adds one with full 64-bit carry in one cycle.
  always_comb begin
    mtime_next = mtime_reg;
    if (wr_mtime_lo) begin
      mtime_next[31:0] = wdata;
    end else if (wr_mtime_hi) begin
      mtime_next[63:32] = wdata;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  // mtime counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_reg <= TMR_MTIME_RST;
    end else begin
      mtime_reg <= mtime_next;
    end
  end

  // mtimecmp halves: each 32-bit half loads only from its own offset.
  logic [1:0] cmp_wr;

  assign cmp_wr = {wr_fire & (word_idx == W_MTIMECMP_HI),
                   wr_fire & (word_idx == W_MTIMECMP_LO)};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
    logic [31:0] half_reg;

    // One mtimecmp half.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        half_reg <= TMR_MTIMECMP_RST[gi*32 +: 32];
      end else if (cmp_wr[gi]) begin
        half_reg <= wdata;
      end
    end
  end

  assign mtimecmp = {g_cmp[1].half_reg, g_cmp[0].half_reg};

  // High-word shadow: a MTIME_LO read snapshots the live high word so the
  // following MTIME_HI read forms a consistent 64-bit pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_shadow_reg <= 32'h0;
    end else if (rd_mtime_lo) begin
      hi_shadow_reg <= mtime_reg[63:32];
    end
  end

  // Interrupt: registered unsigned 64-bit compare gated by EN, held as a level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= en_reg & (mtime_reg >= mtimecmp);
    end
  end

  assign timer_irq = irq_reg;

  // Read mux: combinational from current state, so a same-cycle write is not yet visible.
  always_comb begin
    rdata = 32'h0;
    if (rd_fire) begin
      case (word_idx)
        W_MTIME_LO:    rdata = mtime_reg[31:0];
        W_MTIME_HI:    rdata = hi_shadow_reg;
        W_MTIMECMP_LO: rdata = mtimecmp[31:0];
        W_MTIMECMP_HI: rdata = mtimecmp[63:32];
        W_CTRL:        rdata = {31'h0, en_reg};
`ifdef TIMER_PRESCALER_EN
        W_PRESCALE:    rdata = 32'(presc_reg);
`endif
        default:       rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// tb_timer_intr_ctrl: directed self-checking bench for timer_intr_ctrl.
// Expected values are queued when stimulus is issued and popped at the
// sampling point; each comparison is an immediate assertion.
module tb_timer_intr_ctrl;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [4:0]  addr = 5'h0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        timer_irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  timer_intr_ctrl #(
    .ADDR_W  (5),
    .PRESC_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .timer_irq (timer_irq)
  );

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  // Pop the oldest expectation and compare it against the observed value.
  task automatic pop_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] expv;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL sb_empty: observed %h required a queued expectation", obs);
    end else begin
      tag  = tag_q.pop_front();
      expv = exp_q.pop_front();
      assert (obs === expv) begin
        pass_cnt++;
        $display("chk %-14s observed %h", tag, obs);
      end else begin
        $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    $display("wr  addr %h data %h", a, d);
    @(posedge clk);
    #1;
    sel = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd_exp(input logic [4:0] a, input logic [31:0] expv, input string tag);
    push(tag, expv);
    @(negedge clk);
    sel = 1'b1; rd_en = 1'b1; addr = a;
    #1;
    pop_check(rdata);
    @(posedge clk);
    #1;
    sel = 1'b0; rd_en = 1'b0;
  endtask

  // Read and write the same offset in one cycle: rdata must show the old value.
  task automatic rdwr_exp(input logic [4:0] a, input logic [31:0] d, input logic [31:0] expv,
                          input string tag);
    push(tag, expv);
    @(negedge clk);
    sel = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    #1;
    pop_check(rdata);
    @(posedge clk);
    #1;
    sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Advance to the next falling edge and check the interrupt line.
  task automatic irq_step(input logic expv, input string tag);
    push(tag, {31'h0, expv});
    @(negedge clk);
    #1;
    pop_check({31'h0, timer_irq});
  endtask

  initial begin
    // ---- reset state ----
    idle(2);
    push("rst_irq", 32'h0);
    #1 pop_check({31'h0, timer_irq});
    push("rst_rdata", 32'h0);
    pop_check(rdata);
    @(negedge clk);
    reset = 1'b1;

    rd_exp(TMR_MTIME_LO,    32'h0,        "rst_mtime_lo");
    rd_exp(TMR_MTIME_HI,    32'h0,        "rst_mtime_hi");
    rd_exp(TMR_MTIMECMP_LO, 32'hFFFFFFFF, "rst_cmp_lo");
    rd_exp(TMR_MTIMECMP_HI, 32'hFFFFFFFF, "rst_cmp_hi");
    rd_exp(TMR_CTRL,        32'h0,        "rst_ctrl");
    rd_exp(TMR_PRESCALE,    32'h0,        "rst_presc");

    // ---- basic counting: 10 enabled cycles ----
    wr(TMR_CTRL, 32'h1);
    idle(10);
    rd_exp(TMR_MTIME_LO, 32'd10, "count10");
    irq_step(1'b0, "irq_cmp_ones");

    // ---- interrupt rises the cycle after mtime reaches 20 ----
    wr(TMR_CTRL, 32'h0);
    wr(TMR_MTIME_LO, 32'h0);
    wr(TMR_MTIMECMP_HI, 32'h0);
    wr(TMR_MTIMECMP_LO, 32'd20);
    wr(TMR_CTRL, 32'h1);
    idle(20);
    irq_step(1'b0, "irq_at_20");
    irq_step(1'b1, "irq_after_20");

    // ---- raising mtimecmp drops irq two cycles after the write ----
    wr(TMR_MTIMECMP_LO, 32'd100);
    irq_step(1'b1, "irq_cmp_n1");
    irq_step(1'b0, "irq_cmp_n2");

    // ---- lowering mtimecmp raises irq at N+2; clearing EN drops it at N+2 ----
    wr(TMR_MTIMECMP_LO, 32'h0);
    irq_step(1'b0, "irq_low_n1");
    irq_step(1'b1, "irq_low_n2");
    wr(TMR_CTRL, 32'h0);
    irq_step(1'b1, "irq_en_n1");
    irq_step(1'b0, "irq_en_n2");
    wr(TMR_MTIMECMP_LO, 32'hFFFFFFFF);
    wr(TMR_MTIMECMP_HI, 32'hFFFFFFFF);

    // ---- low-word carry into the high word ----
    wr(TMR_MTIME_HI, 32'h0);
    wr(TMR_MTIME_LO, 32'hFFFFFFFE);
    wr(TMR_CTRL, 32'h1);
    idle(1);
    wr(TMR_CTRL, 32'h0);
    rd_exp(TMR_MTIME_LO, 32'h0, "carry_lo");
    rd_exp(TMR_MTIME_HI, 32'h1, "carry_hi");

    // ---- 64-bit wrap to zero ----
    wr(TMR_MTIME_HI, 32'hFFFFFFFF);
    wr(TMR_MTIME_LO, 32'hFFFFFFFF);
    wr(TMR_CTRL, 32'h1);
    wr(TMR_CTRL, 32'h0);
    rd_exp(TMR_MTIME_LO, 32'h0, "wrap_lo");
    rd_exp(TMR_MTIME_HI, 32'h0, "wrap_hi");

    // ---- high-word shadow keeps the pre-carry value ----
    wr(TMR_MTIME_HI, 32'h5);
    wr(TMR_MTIME_LO, 32'hFFFFFFFF);
    rd_exp(TMR_MTIME_LO, 32'hFFFFFFFF, "shadow_lo");
    wr(TMR_CTRL, 32'h1);
    wr(TMR_CTRL, 32'h0);
    rd_exp(TMR_MTIME_HI, 32'h5, "shadow_hi_old");
    rd_exp(TMR_MTIME_LO, 32'h0, "shadow_lo_new");
    rd_exp(TMR_MTIME_HI, 32'h6, "shadow_hi_new");

    // ---- bus write beats a concurrent tick ----
    wr(TMR_CTRL, 32'h1);
    wr(TMR_MTIME_LO, 32'h7);
    wr(TMR_CTRL, 32'h0);
    rd_exp(TMR_MTIME_LO, 32'h8, "wr_beats_tick");
    rd_exp(TMR_MTIME_HI, 32'h6, "wr_hi_held");

    // ---- same-cycle read/write, decode corner cases ----
    rdwr_exp(TMR_MTIMECMP_LO, 32'h1234, 32'hFFFFFFFF, "rdwr_old");
    rd_exp(TMR_MTIMECMP_LO, 32'h1234, "rdwr_new");
    rd_exp(TMR_MTIMECMP_HI, 32'hFFFFFFFF, "cmp_hi_kept");
    wr(TMR_MTIMECMP_LO, 32'hFFFFFFFF);
    wr(5'h18, 32'hDEADBEEF);
    rd_exp(5'h18, 32'h0, "unmapped_18");
    rd_exp(5'h1C, 32'h0, "unmapped_1c");
    rd_exp(5'h0B, 32'hFFFFFFFF, "byte_lane_ign");
    wr(TMR_CTRL, 32'hFFFFFFFF);
    wr(TMR_CTRL, 32'hFFFFFFFF);
    rd_exp(TMR_CTRL, 32'h1, "ctrl_mask");
    wr(TMR_CTRL, 32'h0);

    wr(TMR_PRESCALE, 32'h3);
`ifdef TIMER_PRESCALER_EN
    rd_exp(TMR_PRESCALE, 32'h3, "presc_read");
    // ---- prescaler: PRESCALE=3 gives one tick per 4 cycles ----
    wr(TMR_MTIME_HI, 32'h0);
    wr(TMR_MTIME_LO, 32'h0);
    wr(TMR_PRESCALE, 32'h3);
    wr(TMR_CTRL, 32'h1);
    idle(11);
    wr(TMR_CTRL, 32'h0);
    rd_exp(TMR_MTIME_LO, 32'd3, "presc_12cyc");
    wr(TMR_CTRL, 32'h1);
    idle(3);
    wr(TMR_MTIME_LO, 32'h5);
    wr(TMR_CTRL, 32'h0);
    rd_exp(TMR_MTIME_LO, 32'h5, "presc_wr_tick");
    wr(TMR_PRESCALE, 32'h0);
`else
    rd_exp(TMR_PRESCALE, 32'h0, "presc_absent");
`endif

    // ---- asynchronous reset mid-count with irq high ----
    wr(TMR_MTIMECMP_HI, 32'h0);
    wr(TMR_MTIMECMP_LO, 32'h0);
    wr(TMR_CTRL, 32'h1);
    idle(2);
    irq_step(1'b1, "pre_rst_irq");
    #2 reset = 1'b0;
    #1;
    push("mid_rst_irq", 32'h0);
    pop_check({31'h0, timer_irq});
    push("mid_rst_rdata", 32'h0);
    pop_check(rdata);
    sel = 1'b1; rd_en = 1'b1; addr = TMR_MTIMECMP_LO;
    #1;
    push("mid_rst_cmp", 32'hFFFFFFFF);
    pop_check(rdata);
    sel = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd_exp(TMR_MTIME_LO, 32'h0, "post_rst_mtime");
    rd_exp(TMR_CTRL, 32'h0, "post_rst_ctrl");
    rd_exp(TMR_MTIMECMP_HI, 32'hFFFFFFFF, "post_rst_cmp");
    rd_exp(TMR_MTIME_LO, 32'h0, "no_count_en0");
    irq_step(1'b0, "post_rst_irq");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
